// File: rtl/sb_rx_pkg.sv
// Package for the UCIe sideband receive decoder.
// Holds opcode constants, header field bit positions, the sideband start
// pattern, the decoder state enum, the queued message struct and the
// CP/DP parity helpers.
package sb_rx_pkg;

  // Header opcodes (header [4:0])
  localparam logic [4:0] OP_MSG_NODATA = 5'b10010;
  localparam logic [4:0] OP_MSG_DATA   = 5'b11011;

  // Sideband start pattern word
  localparam logic [63:0] SB_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

  // Header field bit positions
  localparam int OPCODE_LSB  = 0;
  localparam int OPCODE_MSB  = 4;
  localparam int CODE_LSB    = 14;
  localparam int CODE_MSB    = 21;
  localparam int SUBCODE_LSB = 32;
  localparam int SUBCODE_MSB = 39;
  localparam int INFO_LSB    = 40;
  localparam int INFO_MSB    = 55;
  localparam int DSTID_LSB   = 56;
  localparam int DSTID_MSB   = 58;
  localparam int CP_BIT      = 62;
  localparam int DP_BIT      = 63;

  typedef enum logic [1:0] {
    S_PATTERN = 2'd0,
    S_HDR     = 2'd1,
    S_DATA    = 2'd2
  } sb_rx_state_e;

  typedef struct packed {
    logic        has_data;
    logic [7:0]  code;
    logic [7:0]  subcode;
    logic [15:0] info;
    logic [2:0]  dstid;
    logic [63:0] data;
  } sb_rx_msg_t;

  // Control parity: even parity over header bits [61:0]
  function automatic logic calc_cp(input logic [63:0] hdr);
    return ^hdr[61:0];
  endfunction

  // Data parity: even parity over the whole payload word
  function automatic logic calc_dp(input logic [63:0] payload);
    return ^payload;
  endfunction

  // Build a queue entry from a header word and an optional payload
  function automatic sb_rx_msg_t hdr_to_msg(input logic [63:0] hdr,
                                            input logic        has_data,
                                            input logic [63:0] payload);
    sb_rx_msg_t m;
    m.has_data = has_data;
    m.code     = hdr[CODE_MSB:CODE_LSB];
    m.subcode  = hdr[SUBCODE_MSB:SUBCODE_LSB];
    m.info     = hdr[INFO_MSB:INFO_LSB];
    m.dstid    = hdr[DSTID_MSB:DSTID_LSB];
    m.data     = has_data ? payload : 64'h0;
    return m;
  endfunction

endpackage

// File: rtl/sb_rx_msg_fifo.sv
// Show-ahead message queue for the sideband receive decoder.
// Parameters: DEPTH (power of two, >=2), T (entry type).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the queue)
//   push, push_data   write request and entry; accepted when not full, or
//                     when full and a pop happens in the same cycle
//   pop          remove head (ignored when empty)
//   head         current head entry, all-zero when empty
//   full, empty  occupancy status
module sb_rx_msg_fifo
  import sb_rx_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = sb_rx_msg_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign pop_ok_s  = pop & ~empty;
  // A full queue still takes a push when the head leaves in the same cycle
  assign push_ok_s = push & (~full | pop_ok_s);
  // Head is forced to zero when empty so stale storage never leaks out
  assign head      = empty ? T'(0) : mem_r[rd_ptr_r];

  // Entry storage, written on accepted pushes
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sb_rx_pkt_decoder.sv
// UCIe sideband receive decoder.
// Locks on the sideband start pattern, parses header words and optional
// 64-bit payloads, and queues completed messages in a show-ahead FIFO.
// Optional feature macro: SB_RX_PARITY_CHK_EN enables CP/DP checking; when
// undefined every supported message is queued and o_parity_error stays 0.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_de_ser_done         strobe: i_deser_data holds a complete word
//   i_deser_data          deserialised sideband word
//   i_pattern_search      LTSM requests pattern search mode
//   o_pattern_det         pattern lock (level)
//   o_msg_valid/i_msg_ready  queue head handshake
//   o_msg_*               head message fields
//   o_parity_error        pulse: message dropped on parity
//   o_unsupported         pulse: unknown opcode dropped
//   o_overflow            sticky: message dropped on full queue
//   i_overflow_clr        clears o_overflow (wins over set)
module sb_rx_pkt_decoder
  import sb_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int PATTERN_CNT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_de_ser_done,
  input  logic [63:0] i_deser_data,
  input  logic        i_pattern_search,
  output logic        o_pattern_det,
  output logic        o_msg_valid,
  input  logic        i_msg_ready,
  output logic        o_msg_has_data,
  output logic [7:0]  o_msg_code,
  output logic [7:0]  o_msg_subcode,
  output logic [15:0] o_msg_info,
  output logic [2:0]  o_msg_dstid,
  output logic [63:0] o_msg_data,
  output logic        o_parity_error,
  output logic        o_unsupported,
  output logic        o_overflow,
  input  logic        i_overflow_clr
);

  localparam logic [3:0] PAT_CNT_L = 4'(PATTERN_CNT);

  sb_rx_state_e state_r, state_s;
  logic [3:0]   pat_cnt_r, pat_cnt_s;
  logic         pat_det_r, pat_det_s;
  logic [63:0]  hdr_r, hdr_s;
  logic         par_err_r, par_err_s;
  logic         unsup_r, unsup_s;
  logic         ovf_r;
  logic         push_s;
  sb_rx_msg_t   push_msg_s;
  sb_rx_msg_t   head_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  logic         pop_s;
  logic         ovf_set_s;
  logic         is_pat_s;
  logic         nd_par_ok_s;
  logic         d_par_ok_s;
  logic         unused_s;

  assign is_pat_s = (i_deser_data == SB_PATTERN);

`ifdef SB_RX_PARITY_CHK_EN
  // No-data messages must carry DP=0; data messages check DP against the payload
  assign nd_par_ok_s = (i_deser_data[CP_BIT] == calc_cp(i_deser_data)) &&
                       (i_deser_data[DP_BIT] == 1'b0);
  assign d_par_ok_s  = (hdr_r[CP_BIT] == calc_cp(hdr_r)) &&
                       (hdr_r[DP_BIT] == calc_dp(i_deser_data));
`else
  assign nd_par_ok_s = 1'b1;
  assign d_par_ok_s  = 1'b1;
`endif

  // Header bits outside the queued fields are only needed for parity
  assign unused_s = ^{i_deser_data, hdr_r};

  assign o_msg_valid = ~fifo_empty_s;
  assign pop_s       = o_msg_valid & i_msg_ready;
  assign ovf_set_s   = push_s & fifo_full_s & ~pop_s;

  // Next-state, pattern counting and message assembly
  always_comb begin
    state_s    = state_r;
    pat_cnt_s  = pat_cnt_r;
    pat_det_s  = pat_det_r;
    hdr_s      = hdr_r;
    push_s     = 1'b0;
    push_msg_s = sb_rx_msg_t'(0);
    par_err_s  = 1'b0;
    unsup_s    = 1'b0;
    case (state_r)
      S_PATTERN: begin
        // Leaving pattern search does not wait for a strobe
        if (!i_pattern_search) begin
          state_s   = S_HDR;
          pat_cnt_s = 4'd0;
          pat_det_s = 1'b0;
        end else if (i_de_ser_done) begin
          if (is_pat_s) begin
            if (pat_cnt_r < PAT_CNT_L) begin
              pat_cnt_s = pat_cnt_r + 4'd1;
            end else begin
              pat_cnt_s = pat_cnt_r;
            end
            if (pat_cnt_s == PAT_CNT_L) begin
              pat_det_s = 1'b1;
            end else begin
              pat_det_s = pat_det_r;
            end
          end else begin
            pat_cnt_s = 4'd0;
          end
        end else begin
          state_s = S_PATTERN;
        end
      end
      S_HDR: begin
        if (i_pattern_search) begin
          state_s = S_PATTERN;
        end else if (i_de_ser_done && !is_pat_s) begin
          case (i_deser_data[OPCODE_MSB:OPCODE_LSB])
            OP_MSG_NODATA: begin
              push_msg_s = hdr_to_msg(i_deser_data, 1'b0, 64'h0);
              if (nd_par_ok_s) begin
                push_s = 1'b1;
              end else begin
                par_err_s = 1'b1;
              end
            end
            OP_MSG_DATA: begin
              // Header is held until its payload arrives; parity is judged then
              hdr_s   = i_deser_data;
              state_s = S_DATA;
            end
            default: begin
              unsup_s = 1'b1;
            end
          endcase
        end else begin
          state_s = S_HDR;
        end
      end
      S_DATA: begin
        if (i_pattern_search) begin
          state_s = S_PATTERN;
        end else if (i_de_ser_done) begin
          push_msg_s = hdr_to_msg(hdr_r, 1'b1, i_deser_data);
          state_s    = S_HDR;
          if (d_par_ok_s) begin
            push_s = 1'b1;
          end else begin
            par_err_s = 1'b1;
          end
        end else begin
          state_s = S_DATA;
        end
      end
      default: begin
        state_s = S_PATTERN;
      end
    endcase
  end

  // State, counters and registered status flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= S_PATTERN;
      pat_cnt_r <= 4'd0;
      pat_det_r <= 1'b0;
      hdr_r     <= 64'h0;
      par_err_r <= 1'b0;
      unsup_r   <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      pat_cnt_r <= pat_cnt_s;
      pat_det_r <= pat_det_s;
      hdr_r     <= hdr_s;
      par_err_r <= par_err_s;
      unsup_r   <= unsup_s;
      if (i_overflow_clr) begin
        ovf_r <= 1'b0;
      end else if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  sb_rx_msg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (sb_rx_msg_t)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push_s),
    .push_data (push_msg_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign o_pattern_det  = pat_det_r;
  assign o_msg_has_data = head_s.has_data;
  assign o_msg_code     = head_s.code;
  assign o_msg_subcode  = head_s.subcode;
  assign o_msg_info     = head_s.info;
  assign o_msg_dstid    = head_s.dstid;
  assign o_msg_data     = head_s.data;
  assign o_parity_error = par_err_r;
  assign o_unsupported  = unsup_r;
  assign o_overflow     = ovf_r;

endmodule

// File: tb/tb_sb_rx_pkt_decoder.sv
// Directed self-checking bench for sb_rx_pkt_decoder (FIFO_DEPTH=4,
// PATTERN_CNT=2). Words are driven on the falling edge and outputs are
// sampled on the falling edge after the capturing rising edge.
module tb_sb_rx_pkt_decoder;

  logic        clk;
  logic        rst_n;
  logic        de_ser_done;
  logic [63:0] deser_data;
  logic        pattern_search;
  logic        pattern_det;
  logic        msg_valid;
  logic        msg_ready;
  logic        msg_has_data;
  logic [7:0]  msg_code;
  logic [7:0]  msg_subcode;
  logic [15:0] msg_info;
  logic [2:0]  msg_dstid;
  logic [63:0] msg_data;
  logic        parity_error;
  logic        unsupported;
  logic        overflow;
  logic        overflow_clr;

  int vecs;
  int errs;

  localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

  sb_rx_pkt_decoder #(.FIFO_DEPTH(4), .PATTERN_CNT(2)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_de_ser_done    (de_ser_done),
    .i_deser_data     (deser_data),
    .i_pattern_search (pattern_search),
    .o_pattern_det    (pattern_det),
    .o_msg_valid      (msg_valid),
    .i_msg_ready      (msg_ready),
    .o_msg_has_data   (msg_has_data),
    .o_msg_code       (msg_code),
    .o_msg_subcode    (msg_subcode),
    .o_msg_info       (msg_info),
    .o_msg_dstid      (msg_dstid),
    .o_msg_data       (msg_data),
    .o_parity_error   (parity_error),
    .o_unsupported    (unsupported),
    .o_overflow       (overflow),
    .i_overflow_clr   (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Header with correct CP; dp is placed in bit 63 before CP is computed
  function automatic logic [63:0] mk_hdr(input logic [4:0] op, input logic [7:0] code,
                                         input logic [7:0] sub, input logic [15:0] info,
                                         input logic [2:0] dst, input logic dp);
    logic [63:0] h;
    h = 64'h0;
    h[4:0]   = op;
    h[21:14] = code;
    h[39:32] = sub;
    h[55:40] = info;
    h[58:56] = dst;
    h[63]    = dp;
    h[62]    = ^h[61:0];
    return h;
  endfunction

  task automatic send_word(input logic [63:0] w, input logic rdy);
    @(negedge clk);
    deser_data  = w;
    de_ser_done = 1'b1;
    msg_ready   = rdy;
    @(negedge clk);
    de_ser_done = 1'b0;
    msg_ready   = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; de_ser_done = 1'b0; deser_data = 64'h0; pattern_search = 1'b1;
    msg_ready = 1'b0; overflow_clr = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({pattern_det, msg_valid, msg_has_data, msg_code, msg_subcode, msg_info, msg_dstid,
         msg_data, parity_error, unsupported, overflow} !== 112'h0) begin
      errs++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    rst_n = 1'b1;
  endtask

  task automatic test_pattern();
    send_word(PAT, 1'b0);
    vecs++; if (pattern_det !== 1'b0) begin errs++; $display("FAIL pat_after_1: got %b expected 0", pattern_det); end
    send_word(64'h0000_0000_1234_5678, 1'b0);
    send_word(PAT, 1'b0);
    vecs++; if (pattern_det !== 1'b0) begin errs++; $display("FAIL pat_count_reset: got %b expected 0", pattern_det); end
    send_word(PAT, 1'b0);
    vecs++; if (pattern_det !== 1'b1) begin errs++; $display("FAIL pat_lock: got %b expected 1", pattern_det); end
    @(negedge clk); pattern_search = 1'b0;
    @(negedge clk);
    vecs++; if (pattern_det !== 1'b0) begin errs++; $display("FAIL pat_exit: got %b expected 0", pattern_det); end
  endtask

  task automatic test_nodata();
    send_word(mk_hdr(5'b10010, 8'hA5, 8'h02, 16'h1234, 3'b110, 1'b0), 1'b0);
    vecs++;
    if ({msg_valid, msg_has_data, msg_code, msg_subcode, msg_info, msg_dstid, msg_data} !==
        {1'b1, 1'b0, 8'hA5, 8'h02, 16'h1234, 3'b110, 64'h0}) begin
      errs++; $display("FAIL nodata_fields: got v=%b hd=%b code=%h sub=%h info=%h dst=%b data=%h expected v=1 hd=0 code=a5 sub=02 info=1234 dst=110 data=0",
                       msg_valid, msg_has_data, msg_code, msg_subcode, msg_info, msg_dstid, msg_data);
    end
    pop_one();
    vecs++; if (msg_valid !== 1'b0) begin errs++; $display("FAIL nodata_pop: got valid=%b expected 0", msg_valid); end
  endtask

  task automatic test_data();
    send_word(PAT, 1'b0);
    vecs++; if (msg_valid !== 1'b0) begin errs++; $display("FAIL hdr_pattern_ignored: got valid=%b expected 0", msg_valid); end
    // 0x555 has six set bits, so DP = 0
    send_word(mk_hdr(5'b11011, 8'hA5, 8'h00, 16'h0000, 3'b001, 1'b0), 1'b0);
    vecs++; if (msg_valid !== 1'b0) begin errs++; $display("FAIL data_hdr_only: got valid=%b expected 0", msg_valid); end
    send_word(64'h0000_0000_0000_0555, 1'b0);
    vecs++;
    if ({msg_valid, msg_has_data, msg_code, msg_subcode, msg_dstid, msg_data} !==
        {1'b1, 1'b1, 8'hA5, 8'h00, 3'b001, 64'h555}) begin
      errs++; $display("FAIL data_fields: got v=%b hd=%b code=%h sub=%h dst=%b data=%h expected v=1 hd=1 code=a5 sub=00 dst=001 data=555",
                       msg_valid, msg_has_data, msg_code, msg_subcode, msg_dstid, msg_data);
    end
    pop_one();
    vecs++; if (msg_valid !== 1'b0) begin errs++; $display("FAIL data_single_entry: got valid=%b expected 0", msg_valid); end
  endtask

  task automatic test_parity();
    logic [63:0] h;
    h = mk_hdr(5'b10010, 8'h3C, 8'h01, 16'h0000, 3'b010, 1'b0);
    h[62] = ~h[62];
    send_word(h, 1'b0);
`ifdef SB_RX_PARITY_CHK_EN
    vecs++; if ({parity_error, msg_valid} !== 2'b10) begin errs++; $display("FAIL parity_drop: got perr=%b valid=%b expected perr=1 valid=0", parity_error, msg_valid); end
    @(negedge clk);
    vecs++; if (parity_error !== 1'b0) begin errs++; $display("FAIL parity_pulse: got %b expected 0", parity_error); end
`else
    vecs++; if ({parity_error, msg_valid, msg_code} !== {1'b0, 1'b1, 8'h3C}) begin errs++; $display("FAIL parity_off_queued: got perr=%b valid=%b code=%h expected perr=0 valid=1 code=3c", parity_error, msg_valid, msg_code); end
    pop_one();
`endif
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      send_word(mk_hdr(5'b10010, 8'h10 + 8'(i), 8'h00, 16'h0000, 3'b000, 1'b0), 1'b0);
      if (i == 3) begin
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_at_full: got %b expected 0", overflow); end
      end
    end
    vecs++; if ({overflow, msg_valid, msg_code} !== {1'b1, 1'b1, 8'h10}) begin errs++; $display("FAIL ovf_set: got ovf=%b valid=%b code=%h expected ovf=1 valid=1 code=10", overflow, msg_valid, msg_code); end
    @(negedge clk); overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0;
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      vecs++; if ({msg_valid, msg_code} !== {1'b1, 8'h10 + 8'(i)}) begin errs++; $display("FAIL ovf_order_%0d: got valid=%b code=%h expected valid=1 code=%h", i, msg_valid, msg_code, 8'h10 + 8'(i)); end
      pop_one();
    end
    vecs++; if (msg_valid !== 1'b0) begin errs++; $display("FAIL ovf_drained: got valid=%b expected 0", msg_valid); end
  endtask

  task automatic test_back_to_back();
    // One entry plus simultaneous push and pop: head switches to the new entry
    send_word(mk_hdr(5'b10010, 8'h20, 8'h00, 16'h0000, 3'b000, 1'b0), 1'b0);
    send_word(mk_hdr(5'b10010, 8'h21, 8'h00, 16'h0000, 3'b000, 1'b0), 1'b1);
    vecs++; if ({msg_valid, msg_code} !== {1'b1, 8'h21}) begin errs++; $display("FAIL pushpop_one: got valid=%b code=%h expected valid=1 code=21", msg_valid, msg_code); end
    // Fill to 4 then push while popping: no overflow, order kept
    for (int i = 2; i < 5; i++) send_word(mk_hdr(5'b10010, 8'h20 + 8'(i), 8'h00, 16'h0000, 3'b000, 1'b0), 1'b0);
    send_word(mk_hdr(5'b10010, 8'h25, 8'h00, 16'h0000, 3'b000, 1'b0), 1'b1);
    vecs++; if ({overflow, msg_code} !== {1'b0, 8'h22}) begin errs++; $display("FAIL pushpop_full: got ovf=%b code=%h expected ovf=0 code=22", overflow, msg_code); end
    for (int i = 2; i < 6; i++) begin
      vecs++; if (msg_code !== 8'h20 + 8'(i)) begin errs++; $display("FAIL pushpop_order_%0d: got %h expected %h", i, msg_code, 8'h20 + 8'(i)); end
      pop_one();
    end
  endtask

  task automatic test_unsupported();
    send_word(mk_hdr(5'b00001, 8'h77, 8'h00, 16'h0000, 3'b000, 1'b0), 1'b0);
    vecs++; if ({unsupported, msg_valid} !== 2'b10) begin errs++; $display("FAIL unsup_pulse: got unsup=%b valid=%b expected unsup=1 valid=0", unsupported, msg_valid); end
    @(negedge clk);
    vecs++; if (unsupported !== 1'b0) begin errs++; $display("FAIL unsup_clear: got %b expected 0", unsupported); end
  endtask

  task automatic test_reset_mid();
    send_word(mk_hdr(5'b10010, 8'h30, 8'h00, 16'h0000, 3'b000, 1'b0), 1'b0);
    send_word(mk_hdr(5'b11011, 8'h31, 8'h00, 16'h0000, 3'b000, 1'b0), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (msg_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_valid: got %b expected 0", msg_valid); end
    pattern_search = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    send_word(PAT, 1'b0);
    send_word(PAT, 1'b0);
    vecs++; if ({pattern_det, msg_valid} !== 2'b10) begin errs++; $display("FAIL rst_mid_pattern: got det=%b valid=%b expected det=1 valid=0", pattern_det, msg_valid); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_pattern();
    test_nodata();
    test_data();
    test_parity();
    test_overflow();
    test_back_to_back();
    test_unsupported();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
